data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, synchronous, single-port data memory for the processor datapath; successor of the 16x1024 data memory.
- Adds:
  - generic data/address width and depth;
  - byte-enable writes;
  - a request/ready handshake;
  - selectable read latency;
  - an out-of-range error flag;
  - a post-reset clear sequence.
- Sits between the execute stage load/store path and the RAM array.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, address port width in bits (word address).
- DEPTH, 1024, number of words; must be ≤ 2^ADDR_W.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- CLEAR_ON_RESET, 1, when 1, zero-fill all words after reset before accepting requests.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_DM  in  1  access request, valid this cycle.
- we_DM  in  1  1 = write, 0 = read; sampled with req_DM.
- be_DM  in  DATA_W/8  byte enables for writes; bit i covers dataDM[8i+7:8i].
- addrDM  in  ADDR_W  word address.
- dataDM  in  DATA_W  write data.
- ready_DM  out  1  block accepts a request this cycle.
- outDM  out  DATA_W  read data.
- valid_DM  out  1  one-cycle pulse: outDM holds a read result.
- err_DM  out  1  one-cycle pulse: out-of-range access.

Behaviour:
- Reset (rst_n low, asynchronous):
  - outDM=0, valid_DM=0, err_DM=0, ready_DM=0.
  - Read pipeline flushed; clear counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - After the write to DEPTH-1, go to RUN.
  - Takes exactly DEPTH cycles after reset release.
  - ready_DM=0 throughout; requests ignored, no response.
- RUN: ready_DM=1 continuously; no exit except reset.
- Reset asserted mid-CLEAR or mid-read: pipeline dropped, no valid_DM emitted, clear restarts from address 0.
- Request is accepted on a rising edge only when req_DM && ready_DM.
- Write accept:
  - For each i with be_DM[i]=1, byte i of mem[addrDM] takes dataDM byte i.
  - Other bytes are unchanged.
  - No valid_DM.
  - be_DM all zero is a legal no-op.
- Read accept:
  - outDM=mem[addrDM] and valid_DM=1 exactly READ_LAT cycles after the accept edge, for one cycle.
  - outDM holds its last value while valid_DM=0.
- Throughput: one request per cycle. Back-to-back reads produce back-to-back valid_DM pulses, in order.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. The single port means no same-cycle read/write conflict exists.
- Range check compares the full ADDR_W address with DEPTH:
  - Out-of-range write: dropped, memory unchanged; err_DM pulses 1 cycle after accept.
  - Out-of-range read: returns outDM=0 with valid_DM; err_DM pulses aligned with valid_DM.
- When an err pulse from a write and a valid/err from an earlier read fall in the same cycle, err_DM is the OR of both.
- Inputs are don't-care when req_DM=0.

Decomposition:
- Package data_memory_pkg holds:
  - the state enum (DM_CLEAR, DM_RUN);
  - READ_LAT legality check constants;
  - the function computing the byte count DATA_W/8.
- Sub-module dm_ram_core: synchronous byte-enabled RAM array, one registered read.
  - Parameters DATA_W, DEPTH.
  - Ports clk, en, we, be, addr, din, dout.
- The top level holds the FSM, the clear counter, range check, the extra latency stage for READ_LAT=2, and the valid/err shift registers.

Test Plan:
1. Reset release with DEPTH=1024, CLEAR_ON_RESET=1 → ready_DM low for exactly 1024 cycles, then high; reading address 0x3FF returns 0x0000.
2. Write addr 1=0x1DFE (be=2'b11), next cycle read addr 1 → READ_LAT=1: outDM=0x1DFE with valid_DM one cycle after the read accept; READ_LAT=2: two cycles after.
3. Write addr 2=0xA001 (be=11), then write addr 2=0x55FF with be=2'b01, then read → 0xA0FF.
4. Reads to addr 1,2,3 on consecutive cycles → three consecutive valid_DM pulses with the matching data, in order.
5. Write addr 0x0400=0xBEEF, then read addr 0x0400 → err_DM pulse after the write; the read returns 0x0000 with valid_DM and err_DM together; addr 0x0000 is unchanged.
6. Assert rst_n low mid-CLEAR (cycle 500) and while a read is in flight → no valid_DM pulse; a fresh 1024-cycle CLEAR completes before ready_DM rises.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and helpers for the data memory controller
package data_memory_pkg;

  typedef enum logic {DM_CLEAR, DM_RUN} dm_state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic int dm_byte_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit dm_read_lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/dm_ram_core.sv
// rtl/dm_ram_core.sv - synchronous byte-enabled RAM array with one registered read
module dm_ram_core
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout
);

  localparam int NB = dm_byte_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - parametrised data memory with handshake, range check and post-reset clear
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_DM,
  input  logic                we_DM,
  input  logic [DATA_W/8-1:0] be_DM,
  input  logic [ADDR_W-1:0]   addrDM,
  input  logic [DATA_W-1:0]   dataDM,
  output logic                ready_DM,
  output logic [DATA_W-1:0]   outDM,
  output logic                valid_DM,
  output logic                err_DM
);

  localparam int AW = $clog2(DEPTH);
  localparam int EFF_LAT = dm_read_lat_legal(READ_LAT) ? READ_LAT : READ_LAT_MIN;
  localparam bit LAT2 = (EFF_LAT == READ_LAT_MAX);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam dm_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? DM_CLEAR : DM_RUN;

  dm_state_e state_q, state_d;
  logic [AW-1:0] clr_cnt_q;
  logic ready_q;
  logic accept, in_range;
  logic ram_en, ram_we;
  logic [DATA_W/8-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic rd_v1_q, rd_oor1_q, wr_err_q;
  logic fin_v, fin_oor;
  logic [DATA_W-1:0] d1, fin_d, out_hold_q;

  // Full-width compare so aliasing upper address bits cannot reach the array.
  assign in_range = {1'b0, addrDM} < DEPTH_L;
  assign accept   = req_DM && ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_be   = '0;
    ram_addr = addrDM[AW-1:0];
    ram_din  = dataDM;
    case (state_q)
      DM_CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_be   = '1;
        ram_addr = clr_cnt_q;
        ram_din  = '0;
        if (clr_cnt_q == LAST_ADDR) state_d = DM_RUN;
      end
      DM_RUN: begin
        ram_en = accept && in_range;
        ram_we = we_DM;
        ram_be = be_DM;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      if (state_q == DM_CLEAR) clr_cnt_q <= clr_cnt_q + AW'(1);
      ready_q <= (state_d == DM_RUN);
    end
  end

  dm_ram_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q   <= 1'b0;
      rd_oor1_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      rd_v1_q   <= accept && !we_DM;
      rd_oor1_q <= !in_range;
      wr_err_q  <= accept && we_DM && !in_range;
    end
  end

  // Out-of-range reads never enable the array, so the stale dout is masked here.
  assign d1 = rd_oor1_q ? '0 : ram_dout;

  generate
    if (LAT2) begin : g_lat2
      logic v2_q, oor2_q;
      logic [DATA_W-1:0] d2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q   <= 1'b0;
          oor2_q <= 1'b0;
          d2_q   <= '0;
        end else begin
          v2_q   <= rd_v1_q;
          oor2_q <= rd_oor1_q;
          d2_q   <= d1;
        end
      end
      assign fin_v   = v2_q;
      assign fin_oor = oor2_q;
      assign fin_d   = d2_q;
    end else begin : g_lat1
      assign fin_v   = rd_v1_q;
      assign fin_oor = rd_oor1_q;
      assign fin_d   = d1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     out_hold_q <= '0;
    else if (fin_v) out_hold_q <= fin_d;
  end

  assign outDM    = fin_v ? fin_d : out_hold_q;
  assign valid_DM = fin_v;
  assign err_DM   = wr_err_q | (fin_v & fin_oor);
  assign ready_DM = ready_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl at read latency 1 and 2
module tb_data_memory_ctrl;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_DM = 1'b0, we_DM = 1'b0;
  logic [1:0]  be_DM = '0;
  logic [15:0] addrDM = '0, dataDM = '0;
  logic        ready1, valid1, err1, ready2, valid2, err2;
  logic [15:0] out1, out2;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_DM(req_DM), .we_DM(we_DM), .be_DM(be_DM),
    .addrDM(addrDM), .dataDM(dataDM), .ready_DM(ready1), .outDM(out1),
    .valid_DM(valid1), .err_DM(err1)
  );

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_DM(req_DM), .we_DM(we_DM), .be_DM(be_DM),
    .addrDM(addrDM), .dataDM(dataDM), .ready_DM(ready2), .outDM(out2),
    .valid_DM(valid2), .err_DM(err2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, cycles since reset, recent read results.
  logic [15:0] mem_m [DEPTH];
  int          edges;
  bit          ready_m;
  bit          wr_err_m;
  bit          h_rd [2];
  bit          h_oor [2];
  logic [15:0] h_d [2];
  logic [15:0] last_out [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    edges = 0;
    ready_m = 1'b0;
    wr_err_m = 1'b0;
    for (int k = 0; k < 2; k++) begin
      h_rd[k] = 1'b0; h_oor[k] = 1'b0; h_d[k] = '0; last_out[k] = '0;
    end
  endtask

  // Called with rst_n already low; checks the reset values and releases at a negedge.
  task automatic reset_phase();
    repeat (3) @(negedge clk);
    chk("rst_ready_l1", ready1, 0); chk("rst_ready_l2", ready2, 0);
    chk("rst_valid_l1", valid1, 0); chk("rst_valid_l2", valid2, 0);
    chk("rst_err_l1", err1, 0);     chk("rst_err_l2", err2, 0);
    chk("rst_out_l1", out1, 0);     chk("rst_out_l2", out2, 0);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, let the edge accept, update model, check at next negedge.
  task automatic step(input bit req, input bit we, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] data);
    bit acc, oor;
    req_DM = req; we_DM = we; be_DM = be; addrDM = addr; dataDM = data;
    acc = req && ready_m;
    oor = (addr >= DEPTH);
    @(posedge clk);
    @(negedge clk);
    edges++;
    h_rd[1] = h_rd[0]; h_oor[1] = h_oor[0]; h_d[1] = h_d[0];
    h_rd[0] = acc && !we;
    h_oor[0] = oor;
    h_d[0] = oor ? 16'h0000 : mem_m[addr[9:0]];
    wr_err_m = acc && we && oor;
    if (acc && we && !oor) begin
      if (be[0]) mem_m[addr[9:0]][7:0]  = data[7:0];
      if (be[1]) mem_m[addr[9:0]][15:8] = data[15:8];
    end
    ready_m = (edges >= DEPTH);
    for (int k = 0; k < 2; k++) if (h_rd[k]) last_out[k] = h_d[k];
    chk("ready_l1", ready1, ready_m);  chk("ready_l2", ready2, ready_m);
    chk("valid_l1", valid1, h_rd[0]);  chk("valid_l2", valid2, h_rd[1]);
    chk("err_l1", err1, wr_err_m | (h_rd[0] & h_oor[0]));
    chk("err_l2", err2, wr_err_m | (h_rd[1] & h_oor[1]));
    chk("out_l1", out1, last_out[0]);  chk("out_l2", out2, last_out[1]);
  endtask

  task automatic rand_step();
    logic [15:0] a;
    a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1018, 1031)) : 16'($urandom_range(0, 7));
    if ($urandom_range(0, 31) == 0) a = 16'hFFFF;
    step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), a, 16'($urandom));
  endtask

  task automatic clear_window(input int n);
    for (int i = 0; i < n; i++) rand_step();
  endtask

  initial begin
    model_reset();
    reset_phase();

    // Test 1: ready low for exactly DEPTH cycles, requests ignored, array cleared.
    clear_window(DEPTH);
    chk("t1_ready_up", ready1, 1);
    step(1, 0, 2'b00, 16'h03FF, 16'h0);
    chk("t1_rd3ff_l1", {valid1, out1}, {1'b1, 16'h0000});

    // Test 2: write then read-after-write at both latencies.
    step(1, 1, 2'b11, 16'h0001, 16'h1DFE);
    step(1, 0, 2'b00, 16'h0001, 16'h0);
    chk("t2_raw_l1", {valid1, out1}, {1'b1, 16'h1DFE});
    chk("t2_pend_l2", valid2, 0);
    step(0, 0, 2'b00, 16'h0, 16'h0);
    chk("t2_raw_l2", {valid2, out2}, {1'b1, 16'h1DFE});
    chk("t2_hold_l1", {valid1, out1}, {1'b0, 16'h1DFE});

    // Test 3: partial byte write merges with existing word.
    step(1, 1, 2'b11, 16'h0002, 16'hA001);
    step(1, 1, 2'b01, 16'h0002, 16'h55FF);
    step(1, 0, 2'b00, 16'h0002, 16'h0);
    chk("t3_merge_l1", out1, 16'hA0FF);
    step(1, 1, 2'b00, 16'h0002, 16'h1234);
    chk("t3_merge_l2", out2, 16'hA0FF);

    // Test 4: back-to-back reads, in order.
    step(1, 0, 2'b00, 16'h0001, 16'h0);
    step(1, 0, 2'b00, 16'h0002, 16'h0);
    chk("t4_second_l1", out1, 16'hA0FF);
    step(1, 0, 2'b00, 16'h0003, 16'h0);
    step(0, 0, 2'b00, 16'h0, 16'h0);
    step(0, 0, 2'b00, 16'h0, 16'h0);

    // Test 5: out-of-range write dropped, out-of-range read returns zero with err.
    step(1, 1, 2'b11, 16'h0400, 16'hBEEF);
    chk("t5_werr_l1", err1, 1); chk("t5_werr_l2", err2, 1);
    step(1, 0, 2'b00, 16'h0400, 16'h0);
    chk("t5_rerr_l1", {valid1, err1, out1}, {2'b11, 16'h0000});
    step(1, 0, 2'b00, 16'h0000, 16'h0);
    chk("t5_rerr_l2", {valid2, err2, out2}, {2'b11, 16'h0000});
    step(0, 0, 2'b00, 16'h0, 16'h0);
    chk("t5_addr0_l2", {valid2, out2}, {1'b1, 16'h0000});

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) rand_step();

    // Test 6: reset mid-clear restarts a full clear.
    rst_n = 1'b0;
    reset_phase();
    clear_window(500);
    rst_n = 1'b0;
    reset_phase();
    clear_window(DEPTH);
    chk("t6_ready_up", ready2, 1);

    // Reset while a read is in flight drops it.
    step(1, 1, 2'b11, 16'h0005, 16'hCAFE);
    req_DM = 1'b1; we_DM = 1'b0; addrDM = 16'h0005;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_DM = 1'b0;
    @(negedge clk);
    chk("t6_drop_l1", valid1, 0); chk("t6_drop_l2", valid2, 0);
    reset_phase();
    clear_window(DEPTH);
    step(1, 0, 2'b00, 16'h0005, 16'h0);
    chk("t6_cleared_l1", {valid1, out1}, {1'b1, 16'h0000});
    for (int i = 0; i < 100; i++) rand_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
